// File: rtl/vector_pkg.sv
// Shared definitions for the register-file read selector: default widths and
// the read-sequencer state encoding.
package vector_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned RW_DEF     = 4;
  localparam int unsigned LANE_W_DEF = $clog2(LANES_DEF);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StHold  = 2'd3
  } rrs_state_e;

endpackage

// File: rtl/operand_lane_capture.sv
// Delays the RF read enable/lane by one cycle to line up with returning read
// data, then writes that data into the addressed lane of both operands.
module operand_lane_capture
  import vector_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANES = LANES_DEF,
  localparam int unsigned LW   = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [LW-1:0]          lane,
  input  logic [WIDTH-1:0]       rd_a,
  input  logic [WIDTH-1:0]       rd_b,
  output logic [LANES*WIDTH-1:0] op_a,
  output logic [LANES*WIDTH-1:0] op_b
);

  logic                   en_q, en_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [LANES*WIDTH-1:0] op_a_q, op_a_d;
  logic [LANES*WIDTH-1:0] op_b_q, op_b_d;

  always_comb begin
    en_d   = en & ~clr;
    lane_d = lane;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    // Clearing on accept keeps a scalar result from inheriting a prior vector's upper lanes.
    if (clr) begin
      op_a_d = '0;
      op_b_d = '0;
    end else if (en_q) begin
      op_a_d[lane_q*WIDTH +: WIDTH] = rd_a;
      op_b_d[lane_q*WIDTH +: WIDTH] = rd_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      lane_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      en_q   <= en_d;
      lane_q <= lane_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
    end
  end

  assign op_a = op_a_q;
  assign op_b = op_b_q;

endmodule

// File: rtl/register_read_select.sv
// Operand-read stage between decode and execute: steers reads to the scalar or
// lane-serial vector RF and presents both assembled operands under valid/ready.
module register_read_select
  import vector_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned RW    = RW_DEF,
  localparam int unsigned LW   = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   vf,
  input  logic [RW-1:0]          ra,
  input  logic [RW-1:0]          rb,
  output logic                   renreg,
  output logic                   renvec,
  output logic [RW-1:0]          rda_addr,
  output logic [RW-1:0]          rdb_addr,
  output logic [LW-1:0]          rlane,
  input  logic [WIDTH-1:0]       rd_a,
  input  logic [WIDTH-1:0]       rd_b,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic                   op_vf,
  output logic [LANES*WIDTH-1:0] op_a,
  output logic [LANES*WIDTH-1:0] op_b
);

  localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

  rrs_state_e    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          vf_q, vf_d;
  logic [RW-1:0] ra_q, ra_d;
  logic [RW-1:0] rb_q, rb_d;
  logic          renreg_q, renreg_d;
  logic          renvec_q, renvec_d;
  logic          op_valid_q, op_valid_d;
  logic          accept;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vf_d    = vf_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRead;
          vf_d    = vf;
          ra_d    = ra;
          rb_d    = rb;
          cnt_d   = '0;
        end
      end
      StRead: begin
        if (!vf_q || (cnt_q == LastLane)) begin
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: state_d = StHold;
      StHold: begin
        if (op_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from next-state so they line up with the state they describe.
    renreg_d   = (state_d == StRead) & ~vf_d;
    renvec_d   = (state_d == StRead) & vf_d;
    op_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      vf_q       <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      renreg_q   <= 1'b0;
      renvec_q   <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vf_q       <= vf_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      renreg_q   <= renreg_d;
      renvec_q   <= renvec_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign renreg   = renreg_q;
  assign renvec   = renvec_q;
  assign rda_addr = ra_q;
  assign rdb_addr = rb_q;
  assign rlane    = cnt_q;
  assign op_valid = op_valid_q;
  assign op_vf    = vf_q;

  operand_lane_capture #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_capture (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (renreg_q | renvec_q),
    .lane (cnt_q),
    .rd_a (rd_a),
    .rd_b (rd_b),
    .op_a (op_a),
    .op_b (op_b)
  );

endmodule
